// File: rtl/interrupt_sequencer_pkg.sv
// Shared types and constants for the interrupt sequencer and its return-address stack.
package interrupt_sequencer_pkg;
    localparam int PC_WIDTH_DEF       = 8;
    localparam int STACK_ADDR_LEN_DEF = 2;

    // clrPend is an active-low clear; this is its idle level.
    localparam logic CLR_PEND_INACTIVE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_SAVE   = 3'd2,
        ST_VECTOR = 3'd3,
        ST_RETURN = 3'd4
    } state_t;
endpackage

// File: rtl/interrupt_sequencer_if.sv
// Bundle between the sequencer, the interrupt system and the fetch/decode stage.
interface interrupt_sequencer_if #(
    parameter int pcWidth      = 8,
    parameter int stackAddrLen = 2
);
    logic                    intPending;
    logic [pcWidth-1:0]      isrAddr;
    logic [pcWidth-1:0]      pcCur;
    logic                    instrDone;
    logic                    retiInstr;
    logic                    eiInstr;
    logic                    diInstr;
    logic                    pcLoad;
    logic [pcWidth-1:0]      pcNext;
    logic                    stall;
    logic                    ldIntReg;
    logic                    clrPend;
    logic                    intDisable;
    logic [stackAddrLen:0]   nestDepth;
    logic                    retiErr;

    // master = the sequencer itself, slave = the surrounding core and interrupt system
    modport master (
        input  intPending, isrAddr, pcCur, instrDone, retiInstr, eiInstr, diInstr,
        output pcLoad, pcNext, stall, ldIntReg, clrPend, intDisable, nestDepth, retiErr
    );
    modport slave (
        output intPending, isrAddr, pcCur, instrDone, retiInstr, eiInstr, diInstr,
        input  pcLoad, pcNext, stall, ldIntReg, clrPend, intDisable, nestDepth, retiErr
    );
endinterface

// File: rtl/interrupt_sequencer_ret_addr_stack.sv
// LIFO of return addresses; depth MSB doubles as the full flag since depth never exceeds 2**stackAddrLen.
module ret_addr_stack #(
    parameter int pcWidth      = 8,
    parameter int stackAddrLen = 2
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [pcWidth-1:0]    i_data,
    output logic [pcWidth-1:0]    o_top,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [stackAddrLen:0] o_depth
);
    localparam int DEPTH = 2**stackAddrLen;
    localparam logic [stackAddrLen:0]   DEPTH_ONE = (stackAddrLen+1)'(1);
    localparam logic [stackAddrLen-1:0] IDX_ONE   = stackAddrLen'(1);

    logic [pcWidth-1:0]      r_mem [DEPTH];
    logic [stackAddrLen:0]   r_depth;
    logic [stackAddrLen-1:0] w_wrIdx;
    logic [stackAddrLen-1:0] w_topIdx;

    assign w_wrIdx  = r_depth[stackAddrLen-1:0];
    assign w_topIdx = w_wrIdx - IDX_ONE;
    assign o_full   = r_depth[stackAddrLen];
    assign o_empty  = (r_depth == '0);
    assign o_depth  = r_depth;
    assign o_top    = o_empty ? '0 : r_mem[w_topIdx];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_depth <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_push && !o_full) begin
            r_mem[w_wrIdx] <= i_data;
            r_depth        <= r_depth + DEPTH_ONE;
        end else if (i_pop && !o_empty) begin
            r_depth <= r_depth - DEPTH_ONE;
        end
    end
endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt entry/return sequencer: waits for an instruction boundary, saves the return PC,
// vectors to the ISR and handles EI/DI/RETI with a global enable and bounded nesting.
module interrupt_sequencer
    import interrupt_sequencer_pkg::*;
#(
    parameter int pcWidth      = PC_WIDTH_DEF,
    parameter int stackAddrLen = STACK_ADDR_LEN_DEF
) (
    input  logic                  clk,
    input  logic                  clr,
    interrupt_sequencer_if.master bus
);
    state_t                r_state;
    state_t                w_next;
    logic                  r_gie;
    logic                  r_retiErr;
    logic                  w_full;
    logic                  w_empty;
    logic [pcWidth-1:0]    w_top;
    logic [stackAddrLen:0] w_depth;
    logic                  w_reti;
    logic                  w_ei;
    logic                  w_di;
    logic                  w_ctrlWin;

    assign w_reti    = bus.instrDone & bus.retiInstr;
    assign w_ei      = bus.instrDone & bus.eiInstr;
    assign w_di      = bus.instrDone & bus.diInstr;
    // EI/DI/RETI retire only while the sequencer is not itself driving the PC
    assign w_ctrlWin = (r_state == ST_IDLE) || (r_state == ST_ARM);

    ret_addr_stack #(
        .pcWidth      (pcWidth),
        .stackAddrLen (stackAddrLen)
    ) u_stack (
        .clk     (clk),
        .clr     (clr),
        .i_push  (r_state == ST_SAVE),
        .i_pop   (r_state == ST_RETURN),
        .i_data  (bus.pcCur),
        .o_top   (w_top),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_depth (w_depth)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_reti && !w_empty)
                    w_next = ST_RETURN;
                else if (bus.intPending && r_gie && !w_full && !w_di)
                    w_next = ST_ARM;
            end
            ST_ARM: begin
                if (bus.instrDone)
                    w_next = (w_reti && !w_empty) ? ST_RETURN : ST_SAVE;
            end
            ST_SAVE:   w_next = ST_VECTOR;
            ST_VECTOR: w_next = ST_IDLE;
            ST_RETURN: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_gie     <= 1'b0;
            r_retiErr <= 1'b0;
        end else begin
            r_retiErr <= w_ctrlWin && w_reti && w_empty;
            case (r_state)
                ST_VECTOR: r_gie <= 1'b0;
                ST_RETURN: r_gie <= 1'b1;
                ST_IDLE, ST_ARM: begin
                    if (w_di)      r_gie <= 1'b0;
                    else if (w_ei) r_gie <= 1'b1;
                end
                default: r_gie <= r_gie;
            endcase
        end
    end

    always_comb begin
        bus.stall    = 1'b0;
        bus.pcLoad   = 1'b0;
        bus.pcNext   = '0;
        bus.ldIntReg = 1'b0;
        bus.clrPend  = CLR_PEND_INACTIVE;
        case (r_state)
            ST_IDLE: bus.ldIntReg = 1'b1;
            ST_SAVE: bus.stall    = 1'b1;
            ST_VECTOR: begin
                bus.stall   = 1'b1;
                bus.pcLoad  = 1'b1;
                bus.pcNext  = bus.isrAddr;
                bus.clrPend = ~CLR_PEND_INACTIVE;
            end
            ST_RETURN: begin
                bus.stall  = 1'b1;
                bus.pcLoad = 1'b1;
                bus.pcNext = w_top;
            end
            default: ;
        endcase
    end

    assign bus.intDisable = ~r_gie | w_full | (r_state != ST_IDLE);
    assign bus.nestDepth  = w_depth;
    assign bus.retiErr    = r_retiErr;
endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scenario bench for interrupt_sequencer with a queue-based model of the return stack and gie.
module tb_interrupt_sequencer;
    localparam int PW    = 8;
    localparam int SAL   = 2;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic clr = 1'b0;

    interrupt_sequencer_if #(.pcWidth(PW), .stackAddrLen(SAL)) bus();
    interrupt_sequencer #(.pcWidth(PW), .stackAddrLen(SAL)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    logic [PW-1:0] m_stack [$];
    bit            m_gie = 1'b0;

    // {stall, pcLoad, clrPend, ldIntReg, intDisable, retiErr}
    logic [5:0] ctl;
    assign ctl = {bus.stall, bus.pcLoad, bus.clrPend, bus.ldIntReg, bus.intDisable, bus.retiErr};

    function automatic logic exp_dis();
        return (!m_gie) || (m_stack.size() == DEPTH);
    endfunction

    function automatic logic [5:0] idle_ctl(input logic err);
        return {1'b0, 1'b0, 1'b1, 1'b1, exp_dis(), err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic quiet();
        bus.instrDone = 1'b0;
        bus.retiInstr = 1'b0;
        bus.eiInstr   = 1'b0;
        bus.diInstr   = 1'b0;
    endtask

    task automatic exec_ei_di(input bit en, input string name);
        bus.instrDone = 1'b1;
        bus.eiInstr   = en;
        bus.diInstr   = !en;
        tick();
        quiet();
        m_gie = en;
        tot_cnt++;
        if (ctl !== idle_ctl(1'b0) || bus.nestDepth !== 3'(m_stack.size()))
            $display("FAIL %s: ctl=%b depth=%0d expected ctl=%b depth=%0d", name, ctl, bus.nestDepth, idle_ctl(1'b0), m_stack.size());
        else pass_cnt++;
    endtask

    task automatic enter(input logic [PW-1:0] vec, input logic [PW-1:0] pc, input string name);
        bus.isrAddr    = vec;
        bus.intPending = 1'b1;
        tick();
        tot_cnt++;
        if (ctl !== 6'b001010)
            $display("FAIL %s arm: ctl=%b expected %b", name, ctl, 6'b001010);
        else pass_cnt++;
        repeat ($urandom_range(0, 2)) tick();
        bus.pcCur     = pc;
        bus.instrDone = 1'b1;
        tick();
        quiet();
        tot_cnt++;
        if (ctl !== 6'b101010)
            $display("FAIL %s save: ctl=%b expected %b", name, ctl, 6'b101010);
        else pass_cnt++;
        tick();
        tot_cnt++;
        if (ctl !== 6'b110010 || bus.pcNext !== vec || bus.nestDepth !== 3'(m_stack.size() + 1))
            $display("FAIL %s vector: ctl=%b pcNext=%h depth=%0d expected ctl=%b pcNext=%h depth=%0d",
                     name, ctl, bus.pcNext, bus.nestDepth, 6'b110010, vec, m_stack.size() + 1);
        else pass_cnt++;
        m_stack.push_back(pc);
        m_gie          = 1'b0;
        bus.pcCur      = 8'($urandom);
        bus.intPending = 1'b0;
        tick();
        tot_cnt++;
        if (ctl !== idle_ctl(1'b0) || bus.nestDepth !== 3'(m_stack.size()))
            $display("FAIL %s idle: ctl=%b depth=%0d expected ctl=%b depth=%0d", name, ctl, bus.nestDepth, idle_ctl(1'b0), m_stack.size());
        else pass_cnt++;
        bus.isrAddr = 8'($urandom);
    endtask

    task automatic do_reti(input string name);
        logic [PW-1:0] exp_pc;
        exp_pc        = m_stack[$];
        bus.instrDone = 1'b1;
        bus.retiInstr = 1'b1;
        tick();
        quiet();
        tot_cnt++;
        if (ctl !== 6'b111010 || bus.pcNext !== exp_pc)
            $display("FAIL %s return: ctl=%b pcNext=%h expected ctl=%b pcNext=%h", name, ctl, bus.pcNext, 6'b111010, exp_pc);
        else pass_cnt++;
        void'(m_stack.pop_back());
        m_gie = 1'b1;
        tick();
        tot_cnt++;
        if (ctl !== idle_ctl(1'b0) || bus.nestDepth !== 3'(m_stack.size()))
            $display("FAIL %s idle: ctl=%b depth=%0d expected ctl=%b depth=%0d", name, ctl, bus.nestDepth, idle_ctl(1'b0), m_stack.size());
        else pass_cnt++;
    endtask

    task automatic test_reset();
        clr = 1'b0;
        quiet();
        bus.intPending = 1'b0;
        bus.isrAddr    = '0;
        bus.pcCur      = '0;
        repeat (2) tick();
        tot_cnt++;
        if (ctl !== 6'b001110 || bus.pcNext !== 8'h00 || bus.nestDepth !== 3'd0)
            $display("FAIL reset: ctl=%b pcNext=%h depth=%0d expected ctl=001110 pcNext=00 depth=0", ctl, bus.pcNext, bus.nestDepth);
        else pass_cnt++;
        clr = 1'b1;
        tick();
        tot_cnt++;
        if (ctl !== 6'b001110)
            $display("FAIL reset_release: ctl=%b expected 001110", ctl);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        exec_ei_di(1'b1, "basic_ei");
        enter(8'h40, 8'h12, "basic_entry");
        do_reti("basic_reti");
    endtask

    task automatic test_nesting();
        exec_ei_di(1'b1, "nest_ei0");
        for (int k = 0; k < DEPTH; k++) begin
            enter(8'h40 + 8'(16 * k), 8'($urandom), "nest_entry");
            exec_ei_di(1'b1, "nest_ei");
        end
        bus.intPending = 1'b1;
        repeat (3) begin
            tick();
            tot_cnt++;
            if (ctl !== 6'b001110 || bus.nestDepth !== 3'd4)
                $display("FAIL nest_full_block: ctl=%b depth=%0d expected ctl=001110 depth=4", ctl, bus.nestDepth);
            else pass_cnt++;
        end
        bus.intPending = 1'b0;
        for (int k = 0; k < DEPTH; k++) do_reti("nest_reti");
    endtask

    task automatic test_reti_empty();
        bus.instrDone = 1'b1;
        bus.retiInstr = 1'b1;
        tick();
        quiet();
        tot_cnt++;
        if (ctl !== idle_ctl(1'b1) || bus.pcNext !== 8'h00)
            $display("FAIL reti_empty_pulse: ctl=%b pcNext=%h expected ctl=%b pcNext=00", ctl, bus.pcNext, idle_ctl(1'b1));
        else pass_cnt++;
        tick();
        tot_cnt++;
        if (ctl !== idle_ctl(1'b0))
            $display("FAIL reti_empty_after: ctl=%b expected %b", ctl, idle_ctl(1'b0));
        else pass_cnt++;
    endtask

    task automatic test_reti_vs_entry();
        exec_ei_di(1'b1, "rve_ei");
        enter(8'h21, 8'h9C, "rve_first");
        exec_ei_di(1'b1, "rve_ei2");
        bus.isrAddr    = 8'h33;
        bus.intPending = 1'b1;
        do_reti("rve_reti_first");
        enter(8'h33, 8'h9C, "rve_entry_after");
        do_reti("rve_cleanup");
    endtask

    task automatic test_di_suppress();
        exec_ei_di(1'b1, "di_ei");
        bus.intPending = 1'b1;
        bus.instrDone  = 1'b1;
        bus.diInstr    = 1'b1;
        tick();
        quiet();
        m_gie = 1'b0;
        repeat (2) begin
            tot_cnt++;
            if (ctl !== 6'b001110)
                $display("FAIL di_suppress: ctl=%b expected 001110", ctl);
            else pass_cnt++;
            tick();
        end
        bus.intPending = 1'b0;
    endtask

    task automatic test_reset_mid();
        exec_ei_di(1'b1, "rst_ei");
        enter(8'h48, 8'h31, "rst_pre");
        exec_ei_di(1'b1, "rst_ei2");
        bus.isrAddr    = 8'h5A;
        bus.intPending = 1'b1;
        tick();
        bus.pcCur     = 8'h77;
        bus.instrDone = 1'b1;
        tick();
        quiet();
        tot_cnt++;
        if (ctl !== 6'b101010)
            $display("FAIL rst_save: ctl=%b expected 101010", ctl);
        else pass_cnt++;
        clr = 1'b0;
        tick();
        tot_cnt++;
        if (ctl !== 6'b001110 || bus.pcNext !== 8'h00 || bus.nestDepth !== 3'd0)
            $display("FAIL rst_mid: ctl=%b pcNext=%h depth=%0d expected ctl=001110 pcNext=00 depth=0", ctl, bus.pcNext, bus.nestDepth);
        else pass_cnt++;
        clr = 1'b1;
        m_stack.delete();
        m_gie = 1'b0;
        repeat (2) tick();
        tot_cnt++;
        if (ctl !== 6'b001110 || bus.nestDepth !== 3'd0)
            $display("FAIL rst_gie_off: ctl=%b depth=%0d expected ctl=001110 depth=0", ctl, bus.nestDepth);
        else pass_cnt++;
        bus.intPending = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            if (m_stack.size() == 0 || (m_stack.size() < DEPTH && $urandom_range(0, 1) == 1)) begin
                if (!m_gie) exec_ei_di(1'b1, "rand_ei");
                enter(8'($urandom), 8'($urandom), "rand_entry");
            end else begin
                do_reti("rand_reti");
            end
        end
        while (m_stack.size() > 0) do_reti("rand_drain");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_nesting();
        test_reti_empty();
        test_reti_vs_entry();
        test_di_suppress();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
